fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Consumer stage directly downstream of the 8-entry, 32-bit FIFO.
- On a start command it drains a burst of 1..8 words from the FIFO through its rd_en/d_out/rd_ack/rd_err interface.
- It accumulates the words into an unsigned sum and presents the sum with a valid/ready handshake.
- It never issues a read when the FIFO reports empty.

Parameters:
- DATA_W, 32, FIFO data width.
- SUM_W, 35, accumulator width; DATA_W+3 holds 8 maximum words without overflow.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- burst_len  input  4  words to read, valid 1..8; latched on an accepted start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_ack  input  1  FIFO read acknowledge; fifo_d_out is valid in this cycle.
- fifo_rd_err  input  1  FIFO read error.
- fifo_d_out  input  DATA_W  FIFO read data.
- fifo_rd_en  output  1  read request to the FIFO.
- sum  output  SUM_W  accumulated sum, held stable while sum_valid=1.
- word_cnt  output  4  words received in the current or last burst.
- sum_valid  output  1  result available.
- sum_ready  input  1  consumer accepts the result.
- busy  output  1  high in READ and DONE.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset: all registers clear synchronously when reset_n=0 at a clk edge, from any state.
  - State goes to IDLE.
  - fifo_rd_en=0, sum=0, word_cnt=0, sum_valid=0, busy=0, err=0.
  - Internal counters issued=0 and latched length=0.
  - A reset mid-burst abandons the burst. Any in-flight read data is dropped.
- States: IDLE, READ, DONE. Encoded in a 2-bit state register with combinational next-state logic.
- IDLE:
  - start=1 with burst_len in 1..8: latch burst_len, clear sum, word_cnt, issued and err, then go to READ.
  - start=1 with burst_len=0 or >8: set err=1 and stay in IDLE.
- READ, issue side:
  - fifo_rd_en = (issued < len) && !fifo_empty. This is combinational from registered state/counters and the fifo_empty input.
  - issued increments on each cycle with fifo_rd_en=1.
  - At most one read is issued per cycle, so back-to-back reads are allowed.
- READ, receive side:
  - FIFO read latency is 1 cycle: rd_en in cycle t gives rd_ack=1 and valid d_out in cycle t+1.
  - On each cycle with fifo_rd_ack=1: sum <= sum + zero-extended fifo_d_out, and word_cnt <= word_cnt+1.
  - fifo_rd_ack outside READ is ignored.
- READ exit:
  - When word_cnt+(fifo_rd_ack?1:0) == len, go to DONE at that edge.
  - The sum registered at that edge includes the final word.
- Empty handling: if fifo_empty=1, reads stall with no timeout. The block waits in READ indefinitely for data.
- fifo_rd_err=1 in any state sets err=1. Sum and count are unaffected. The burst continues.
- DONE:
  - sum_valid=1; sum and word_cnt are held.
  - sum_valid=1 && sum_ready=1: go to IDLE at that edge and deassert sum_valid in the next cycle.
  - sum and word_cnt keep their last values in IDLE until the next accepted start.
- start in READ or DONE is ignored.
- busy = (state != IDLE).
- Arithmetic: unsigned, SUM_W bits. The maximum 8 × (2^32-1) fits, so no wrap occurs.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, fifo_rd_en never asserted.
- Basic burst: FIFO preloaded with 1,2,3,4; start with burst_len=4 and sum_ready=1 -> fifo_rd_en high for 4 consecutive cycles, then sum_valid=1 with sum=10 and word_cnt=4, then back to IDLE.
- Stall on empty: FIFO holds 2 words (5,7), burst_len=4; write 9,11 ten cycles later -> fifo_rd_en drops while empty, then resumes. Final sum=32, and the FIFO never asserts rd_err.
- Max values: 8 words of 0xFFFFFFFF, burst_len=8 -> sum=0x7FFFFFFF8, word_cnt=8.
- Handshake hold: sum_ready=0 for 5 cycles in DONE -> sum_valid and sum are stable. start pulses are ignored. Exit to IDLE occurs on the cycle sum_ready=1.
- Errors and abort:
  - burst_len=0 on start -> err=1, stays in IDLE.
  - A forced fifo_rd_err pulse -> err=1.
  - reset_n=0 mid-READ after 2 of 4 words -> IDLE with sum=0 on the next cycle.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Burst consumer for the 8-entry FIFO. It drains 1..8 words, accumulates their unsigned sum
// and offers the result on a valid/ready handshake.
module fifo_burst_reader #(
  parameter int DATA_W = 32,
  parameter int SUM_W  = 35
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        burst_len,
  input  logic              fifo_empty,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  input  logic [DATA_W-1:0] fifo_d_out,
  output logic              fifo_rd_en,
  output logic [SUM_W-1:0]  sum,
  output logic [3:0]        word_cnt,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [3:0]       len_r;
  logic [3:0]       issued_r;
  logic [3:0]       word_cnt_r;
  logic [SUM_W-1:0] sum_r;
  logic             sum_valid_r;
  logic             busy_r;
  logic             err_r;

  logic             len_ok_s;
  logic             start_ok_s;
  logic             start_bad_s;
  logic             ack_s;
  logic             rd_en_s;
  logic [3:0]       cnt_plus_s;
  logic             last_word_s;
  logic [SUM_W-1:0] sum_add_s;

  // Handshake qualifiers and the issue/receive datapath terms
  always_comb begin
    len_ok_s    = (burst_len >= 4'd1) && (burst_len <= 4'd8);
    start_ok_s  = (state_r == ST_IDLE) && start && len_ok_s;
    start_bad_s = (state_r == ST_IDLE) && start && !len_ok_s;
    ack_s       = (state_r == ST_READ) && fifo_rd_ack;
    rd_en_s     = (state_r == ST_READ) && (issued_r < len_r) && !fifo_empty;
    cnt_plus_s  = word_cnt_r + {3'b000, ack_s};
    last_word_s = (state_r == ST_READ) && (cnt_plus_s == len_r);
    sum_add_s   = sum_r + {{(SUM_W-DATA_W){1'b0}}, fifo_d_out};
  end

  // Next-state logic; the exit from READ fires on the edge that captures the final word
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) next_state_s = ST_READ;
        else            next_state_s = ST_IDLE;
      end
      ST_READ: begin
        if (last_word_s) next_state_s = ST_DONE;
        else             next_state_s = ST_READ;
      end
      ST_DONE: begin
        if (sum_ready) next_state_s = ST_IDLE;
        else           next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, counters, accumulator and registered status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      len_r       <= 4'd0;
      issued_r    <= 4'd0;
      word_cnt_r  <= 4'd0;
      sum_r       <= {SUM_W{1'b0}};
      sum_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != ST_IDLE);
      sum_valid_r <= (next_state_s == ST_DONE);
      if (start_ok_s) begin
        len_r      <= burst_len;
        issued_r   <= 4'd0;
        word_cnt_r <= 4'd0;
        sum_r      <= {SUM_W{1'b0}};
      end else begin
        if (rd_en_s) issued_r <= issued_r + 4'd1;
        if (ack_s) begin
          sum_r      <= sum_add_s;
          word_cnt_r <= cnt_plus_s;
        end
      end
      // A read error in the same cycle as an accepted start still counts
      if (fifo_rd_err || start_bad_s) err_r <= 1'b1;
      else if (start_ok_s)            err_r <= 1'b0;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign sum        = sum_r;
  assign word_cnt   = word_cnt_r;
  assign sum_valid  = sum_valid_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural 1-cycle-latency FIFO plus a scoreboard of
// expected burst sums, compared when each result first becomes valid.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  burst_len;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_ack = 1'b0;
  logic        fifo_rd_err;
  logic [31:0] fifo_d_out = 32'd0;
  logic        fifo_rd_en;
  logic [34:0] sum;
  logic [3:0]  word_cnt;
  logic        sum_valid;
  logic        sum_ready;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;
  int underflow = 0;

  logic [31:0] push_q[$];
  logic [31:0] fifo_q[$];
  logic [34:0] exp_sum_q[$];
  logic [3:0]  exp_cnt_q[$];
  logic        sv_prev = 1'b0;

  fifo_burst_reader #(.DATA_W(32), .SUM_W(35)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
    .fifo_d_out(fifo_d_out), .fifo_rd_en(fifo_rd_en), .sum(sum), .word_cnt(word_cnt),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on rd_en, data/ack one cycle later; staged writes land at the edge
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_ack <= 1'b1;
      if (fifo_q.size() == 0) begin
        underflow++;
        fifo_d_out <= 32'hDEAD_BEEF;
      end else begin
        fifo_d_out <= fifo_q.pop_front();
      end
    end else begin
      fifo_rd_ack <= 1'b0;
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Scoreboard: compare each result when sum_valid first rises
  always @(negedge clk) begin
    if (reset_n === 1'b1 && sum_valid === 1'b1 && sv_prev === 1'b0) begin
      tests++;
      if (exp_sum_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: sum=%0h word_cnt=%0d, no result expected", sum, word_cnt);
      end else begin
        logic [34:0] es;
        logic [3:0]  ec;
        es = exp_sum_q.pop_front();
        ec = exp_cnt_q.pop_front();
        if (sum !== es || word_cnt !== ec) begin
          fails++;
          $display("FAIL sb_result: sum=%0h word_cnt=%0d, expected sum=%0h word_cnt=%0d",
                   sum, word_cnt, es, ec);
        end
      end
    end
    sv_prev = sum_valid;
  end

  task automatic start_burst(input logic [3:0] len);
    start = 1'b1;
    burst_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (sum_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (sum_valid === 1'b1);
  endtask

  task automatic wait_cnt(input logic [3:0] c, output bit ok);
    int n;
    n = 0;
    while (word_cnt !== c && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (word_cnt === c);
  endtask

  task automatic test_reset;
    int rd_seen;
    rd_seen = 0;
    reset_n = 1'b0;
    start = 1'b1;
    burst_len = 4'd4;
    sum_ready = 1'b1;
    fifo_rd_err = 1'b0;
    push_q.push_back(32'd99);
    repeat (2) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) rd_seen++;
    end
    tests++;
    if (rd_seen != 0 || sum !== 35'd0 || word_cnt !== 4'd0 || sum_valid !== 1'b0 ||
        busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rd_en_cycles=%0d sum=%0h cnt=%0d valid=%b busy=%b err=%b, expected all 0",
               rd_seen, sum, word_cnt, sum_valid, busy, err);
    end
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    fifo_q.delete();
    @(negedge clk);
  endtask

  task automatic test_basic;
    int hi, run, max_run, n;
    bit ok;
    hi = 0; run = 0; max_run = 0; n = 0;
    sum_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_q.push_back(32'(i));
    exp_sum_q.push_back(35'd10);
    exp_cnt_q.push_back(4'd4);
    start_burst(4'd4);
    while (sum_valid !== 1'b1 && n < 200) begin
      if (fifo_rd_en === 1'b1) begin
        hi++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(negedge clk);
      n++;
    end
    ok = (sum_valid === 1'b1);
    tests++;
    if (!ok || hi != 4 || max_run != 4) begin
      fails++;
      $display("FAIL basic_rd_en: valid=%b rd_en_cycles=%0d longest_run=%0d, expected 4 and 4",
               ok, hi, max_run);
    end
    @(negedge clk);
    tests++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum !== 35'd10 || word_cnt !== 4'd4) begin
      fails++;
      $display("FAIL basic_idle: valid=%b busy=%b sum=%0d cnt=%0d, expected 0 0 10 4",
               sum_valid, busy, sum, word_cnt);
    end
  endtask

  task automatic test_stall_empty;
    int hi;
    bit ok;
    hi = 0;
    sum_ready = 1'b1;
    push_q.push_back(32'd5);
    push_q.push_back(32'd7);
    exp_sum_q.push_back(35'd32);
    exp_cnt_q.push_back(4'd4);
    start_burst(4'd4);
    wait_cnt(4'd2, ok);
    repeat (10) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) hi++;
    end
    tests++;
    if (!ok || hi != 0 || busy !== 1'b1 || sum_valid !== 1'b0 || sum !== 35'd12) begin
      fails++;
      $display("FAIL stall_hold: reached2=%b rd_en_cycles=%0d busy=%b valid=%b sum=%0d, expected 1 0 1 0 12",
               ok, hi, busy, sum_valid, sum);
    end
    push_q.push_back(32'd9);
    push_q.push_back(32'd11);
    wait_valid(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_resume: sum_valid=%b word_cnt=%0d, expected valid after refill",
               sum_valid, word_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_max_values;
    bit ok;
    sum_ready = 1'b1;
    repeat (8) push_q.push_back(32'hFFFF_FFFF);
    exp_sum_q.push_back(35'h7_FFFF_FFF8);
    exp_cnt_q.push_back(4'd8);
    start_burst(4'd8);
    wait_valid(ok);
    tests++;
    if (!ok || sum !== 35'h7_FFFF_FFF8 || word_cnt !== 4'd8) begin
      fails++;
      $display("FAIL max_sum: valid=%b sum=%0h cnt=%0d, expected 7fffffff8 and 8", ok, sum, word_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_handshake_hold;
    bit ok;
    sum_ready = 1'b0;
    push_q.push_back(32'd100);
    push_q.push_back(32'd200);
    push_q.push_back(32'd300);
    exp_sum_q.push_back(35'd600);
    exp_cnt_q.push_back(4'd3);
    start_burst(4'd3);
    wait_valid(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hold_reach: sum_valid=%b, expected 1", sum_valid);
    end
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      burst_len = 4'd2;
      @(negedge clk);
      tests++;
      if (sum_valid !== 1'b1 || sum !== 35'd600 || word_cnt !== 4'd3 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_cycle%0d: valid=%b sum=%0d cnt=%0d busy=%b, expected 1 600 3 1",
                 i, sum_valid, sum, word_cnt, busy);
      end
    end
    start = 1'b0;
    sum_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum !== 35'd600 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL hold_exit: valid=%b busy=%b sum=%0d rd_en=%b, expected 0 0 600 0",
               sum_valid, busy, sum, fifo_rd_en);
    end
  endtask

  task automatic test_errors;
    bit ok;
    sum_ready = 1'b1;
    start_burst(4'd0);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_len0: err=%b busy=%b, expected 1 0", err, busy);
    end
    start_burst(4'd9);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_len9: err=%b busy=%b, expected 1 0", err, busy);
    end
    push_q.push_back(32'd6);
    push_q.push_back(32'd8);
    exp_sum_q.push_back(35'd14);
    exp_cnt_q.push_back(4'd2);
    start_burst(4'd2);
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL err_clear: err=%b busy=%b, expected 0 1", err, busy);
    end
    fifo_rd_err = 1'b1;
    @(negedge clk);
    fifo_rd_err = 1'b0;
    wait_valid(ok);
    tests++;
    if (!ok || err !== 1'b1) begin
      fails++;
      $display("FAIL err_rd_err: valid=%b err=%b, expected 1 1", ok, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    bit ok;
    sum_ready = 1'b1;
    push_q.push_back(32'd20);
    push_q.push_back(32'd22);
    start_burst(4'd4);
    wait_cnt(4'd2, ok);
    tests++;
    if (!ok || sum !== 35'd42) begin
      fails++;
      $display("FAIL abort_mid: cnt=%0d sum=%0d, expected 2 42", word_cnt, sum);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tests++;
    if (sum !== 35'd0 || word_cnt !== 4'd0 || busy !== 1'b0 || sum_valid !== 1'b0 ||
        err !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: sum=%0d cnt=%0d busy=%b valid=%b err=%b rd_en=%b, expected all 0",
               sum, word_cnt, busy, sum_valid, err, fifo_rd_en);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b rd_en=%b, expected 0 0", busy, fifo_rd_en);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    burst_len = 4'd0;
    fifo_rd_err = 1'b0;
    sum_ready = 1'b1;
    test_reset;
    test_basic;
    test_stall_empty;
    test_max_values;
    test_handshake_hold;
    test_errors;
    test_reset_abort;
    tests++;
    if (underflow != 0 || exp_sum_q.size() != 0) begin
      fails++;
      $display("FAIL final: empty_reads=%0d pending_results=%0d, expected 0 0",
               underflow, exp_sum_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
